// File: rtl/intr_cond_pkg.sv
// Shared definitions for the interrupt conditioner: trigger-mode encodings
// and filter counter sizing helpers.
package intr_cond_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_e;

    // A filter setting of 0 still needs one cycle to accept a change.
    function automatic int filt_len(int filter_cycles);
        return (filter_cycles < 1) ? 1 : filter_cycles;
    endfunction

    function automatic int cnt_width(int filter_cycles);
        return $clog2(filt_len(filter_cycles) + 1);
    endfunction

endpackage

// File: rtl/intr_cond_chan.sv
// One interrupt channel: synchronizer, stability filter, edge detect and
// sticky pending bit.
module intr_cond_chan
    import intr_cond_pkg::*;
#(
    parameter int SYNC_STAGE    = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pending,
    output logic       level
);

    localparam int             FP      = filt_len(FILTER_CYCLES);
    localparam int             CW      = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FP - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
    logic          s;
    logic          filt;
    logic          filt_d;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;
    logic          edge_hit;

    assign s = sync_q[SYNC_STAGE-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], intr_in};
        end
    end

    // A change on s is taken only after FP consecutive differing samples;
    // any return to the current value restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b0;
            filt_d <= 1'b0;
            cnt    <= '0;
        end else begin
            filt_d <= filt;
            if (s == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                filt <= s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    always_comb begin
        edge_hit = 1'b0;
        unique case (mode_e'(mode))
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = 1'b0;
        endcase
    end

    // Edge beats clear so an event arriving with a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (mode_e'(mode) == MODE_LEVEL) begin
            pending <= filt;
        end else if (edge_hit) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    assign level = filt;

endmodule

// File: rtl/intr_cond_sync.sv
// Multi-channel interrupt conditioner: per-channel conditioning plus the
// masked OR reduction that drives the registered irq_out.
module intr_cond_sync
    import intr_cond_pkg::*;
#(
    parameter int INTR_WIDTH    = 4,
    parameter int SYNC_STAGE    = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INTR_WIDTH-1:0]   intr_in,
    input  logic [2*INTR_WIDTH-1:0] mode_cfg,
    input  logic [INTR_WIDTH-1:0]   intr_mask,
    input  logic                    clr_valid,
    input  logic [INTR_WIDTH-1:0]   clr_mask,
    output logic [INTR_WIDTH-1:0]   pending,
    output logic [INTR_WIDTH-1:0]   level,
    output logic                    irq_out
);

    for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_chan
        intr_cond_chan #(
            .SYNC_STAGE    (SYNC_STAGE),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .intr_in (intr_in[i]),
            .mode    (mode_cfg[2*i +: 2]),
            .clr     (clr_valid & clr_mask[i]),
            .pending (pending[i]),
            .level   (level[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= |(pending & ~intr_mask);
        end
    end

endmodule
